// File: rtl/display_pkg.sv
// display_pkg: page encodings and scheduler state shared by the display path.
package display_pkg;
    localparam logic [1:0] PAGE_PWR   = 2'd0;
    localparam logic [1:0] PAGE_WORK  = 2'd1;
    localparam logic [1:0] PAGE_ALERT = 2'd2;
    typedef enum logic [1:0] {ST_OFF, ST_SHOW_PWR, ST_SHOW_WORK, ST_ALERT} disp_state_t;
endpackage

// File: rtl/tick_counter.sv
// tick_counter: up-counter on inc with synchronous clear; wraps or saturates at MAX.
module tick_counter #(
    parameter int MAX  = 4,
    parameter bit WRAP = 1'b1,
    parameter int W    = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    localparam logic [W-1:0] TOP = W'(MAX);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc) count <= (count == TOP) ? (WRAP ? '0 : count) : count + 1'b1;
endmodule

// File: rtl/display_page_scheduler.sv
// display_page_scheduler: picks which page the shared 7-segment display shows,
// with manual/auto page rotation and a preemptive, blinking alert page.
module display_page_scheduler import display_pkg::*; #(
    parameter int ROTATE_SEC     = 5,
    parameter int ALERT_HOLD_SEC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic       tick_half,
    input  logic       en,
    input  logic       auto_mode,
    input  logic       btn_next,
    input  logic       alert_req,
    input  logic [5:0] power_on_hour,
    input  logic [5:0] working_hour,
    output logic [1:0] page_sel,
    output logic       hour_view,
    output logic       disp_en,
    output logic       alert_ack
);
    localparam int RW = $clog2(ROTATE_SEC);
    localparam int HW = $clog2(ALERT_HOLD_SEC + 1);
    disp_state_t state, nxt;
    logic saved_page, blink, nxt_blink;
    logic in_show, cur_page, grant, toggle, leave, rot_clr, hold_clr;
    logic [RW-1:0] rot_count;
    logic [HW-1:0] hold_count;
    tick_counter #(.MAX(ROTATE_SEC - 1), .WRAP(1'b1), .W(RW)) u_rotate (
        .clk(clk), .rst(rst), .clr(rot_clr), .inc(tick_1s), .count(rot_count)
    );
    tick_counter #(.MAX(ALERT_HOLD_SEC), .WRAP(1'b0), .W(HW)) u_hold (
        .clk(clk), .rst(rst), .clr(hold_clr), .inc(tick_1s), .count(hold_count)
    );
    // Priority: en low > alert grant > button > rotate tick; losers are dropped.
    always_comb begin
        in_show   = state == ST_SHOW_PWR || state == ST_SHOW_WORK;
        cur_page  = state == ST_SHOW_WORK;
        grant     = en && in_show && alert_req;
        toggle    = en && in_show && !alert_req &&
                    (btn_next || (auto_mode && tick_1s && rot_count == RW'(ROTATE_SEC - 1)));
        leave     = state == ST_ALERT && !alert_req && hold_count == HW'(ALERT_HOLD_SEC);
        rot_clr   = !en || !in_show || alert_req || btn_next || !auto_mode;
        hold_clr  = !en || state != ST_ALERT;
        nxt       = !en ? ST_OFF :
                    state == ST_OFF ? ST_SHOW_PWR :
                    grant ? ST_ALERT :
                    leave ? (saved_page ? ST_SHOW_WORK : ST_SHOW_PWR) :
                    toggle ? (cur_page ? ST_SHOW_PWR : ST_SHOW_WORK) : state;
        nxt_blink = nxt == ST_ALERT && (state != ST_ALERT || (blink ^ tick_half));
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= ST_OFF;
            saved_page <= 1'b0;
            blink      <= 1'b0;
            page_sel   <= PAGE_PWR;
            hour_view  <= 1'b0;
            disp_en    <= 1'b0;
            alert_ack  <= 1'b0;
        end else begin
            state      <= nxt;
            blink      <= nxt_blink;
            alert_ack  <= grant;
            if (grant) saved_page <= cur_page;
            page_sel   <= nxt == ST_ALERT ? PAGE_ALERT : nxt == ST_SHOW_WORK ? PAGE_WORK : PAGE_PWR;
            disp_en    <= nxt == ST_ALERT ? nxt_blink : nxt != ST_OFF;
            hour_view  <= nxt == ST_SHOW_PWR  ? power_on_hour != 6'd0 :
                          nxt == ST_SHOW_WORK ? working_hour != 6'd0 : 1'b0;
        end
endmodule
